lfsr_stream: RTL and testbench
==============================

// Module: lfsr_stream
// PURPOSE
//  Parametrised LFSR random-word source with a valid/ready output handshake.
//  Generalises the fixed 20-bit/3-bit LFSR transfer function to any width, tap set,
//  word width and steps per clock. Adds runtime seeding, lock-up protection and backpressure.
//  Feeds game logic (robot moves, animation jitter) with a stream of N-bit random words.
// PARAMETERS
//  WIDTH         20          LFSR state width, >= 2
//  TAPS          20'h90000   feedback mask (bits 19,16), maximal-length for WIDTH=20
//  OUT_BITS      3           bits per output word; 1 <= OUT_BITS <= WIDTH
//  STEPS_PER_CLK 3           LFSR steps per clock; must divide OUT_BITS
//  SEED_DEFAULT  1           state loaded on rst; 0 is replaced by 1
// PORTS
//  clk        in   1         system clock, rising edge
//  rst        in   1         synchronous reset, active high
//  seed_load  in   1         load 'seed' this cycle; flushes any pending word
//  seed       in   WIDTH     new LFSR state
//  out_data   out  OUT_BITS  random word, valid while out_valid
//  out_valid  out  1         word available
//  out_ready  in   1         consumer accepts word when out_valid && out_ready
//  busy       out  1         engine is generating (FSM in FILL)
// BEHAVIOUR
//  Step: fb = ^(state & TAPS); state <= {state[WIDTH-2:0], fb}. Fibonacci form, shift left.
//  Word = state[OUT_BITS-1:0] after OUT_BITS steps from the previous word boundary.
//  C = OUT_BITS/STEPS_PER_CLK cycles per word; a step counter counts 0..C-1.
//  Reset: state=SEED_DEFAULT (0->1), out_data=0, out_valid=0, counter=0, FSM=FILL, busy=1.
//  FSM FILL: each cycle advance STEPS_PER_CLK steps and increment the counter.
//   - On the cycle the counter reaches C-1 the word is complete.
//   - If the slot is free (!out_valid, or out_valid && out_ready this cycle), load
//     out_data, set out_valid=1, reset the counter and stay in FILL.
//   - Otherwise go to WAIT with state frozen at the completed word.
//  FSM WAIT: busy=0, state frozen.
//   - On out_valid && out_ready, load out_data from state[OUT_BITS-1:0] and return to FILL.
//   - No word is ever skipped or duplicated.
//  Throughput: 1 word per C cycles with out_ready held high; no bubble.
//   - With C=1, out_valid stays high continuously.
//  Latency: out_valid rises on the C-th edge after the last cycle with rst or seed_load high.
//  seed_load (priority below rst, above all else):
//   - state <= (seed==0 ? 1 : seed); out_valid <= 0; counter <= 0; FSM <= FILL.
//   - The flush drops out_valid without a handshake.
//   - If out_ready is also high that cycle, the presented word counts as consumed.
//  Lock-up guard: all-zero state is only reachable via seed and is replaced by 1.
//  out_data holds its value while out_valid=0. Its X-free value after reset is 0.
//  rst mid-word or mid-WAIT: everything returns to reset values on the next edge.
// STRUCTURE
//  Shared config header: `define LFSR20_TAPS 20'h90000, with SEED_DEFAULT used by game modules.
//  Sub-module lfsr_multi_step #(WIDTH,TAPS,STEPS): combinational, in[WIDTH] -> out[WIDTH],
//   a generate-loop of STEPS single steps.
//  lfsr_stream holds the state reg, step counter, 2-state FSM and 1-deep output register.
// TESTING
//  1 WIDTH=20, OUT_BITS=3, STEPS=3, seed_load seed=20'h10000, out_ready=1:
//    -> words 3'b100, 3'b100, 3'b000.
//    -> internal state 20'h80004, 20'h00024, 20'h00120.
//    -> out_valid high 2 edges after seed_load.
//  2 Same seed, STEPS=1: identical word sequence, one word per 3 cycles.
//    -> busy stays 1.
//  3 out_ready=0 for 10 cycles after the first word:
//    -> out_valid=1 with word held; FSM reaches WAIT with busy=0.
//    -> After release: no skipped or duplicate words versus test 1.
//  4 seed=0 vs seed=1: word streams identical; state never reads 0.
//  5 seed_load while out_valid=1 and out_ready=0:
//    -> out_valid=0 next cycle; new stream restarts per the latency rule.
//    -> rst mid-FILL gives reset values.
//  6 STEPS=1, OUT_BITS=1, seed=1: state returns to 1 after exactly 2^20-1 words.
//    -> never all-zero.

Source files
------------

// File: rtl/lfsr_stream_pkg.sv
// Shared LFSR stream definitions: the 20-bit maximal-length configuration and FSM states.
`ifndef LFSR20_TAPS
`define LFSR20_TAPS 20'h90000
`endif

package lfsr_stream_pkg;

  localparam int unsigned LFSR20_WIDTH        = 20;
  localparam logic [19:0] LFSR20_TAPS         = `LFSR20_TAPS;
  localparam logic [19:0] LFSR20_SEED_DEFAULT = 20'd1;

  typedef enum logic {
    S_FILL = 1'b0,
    S_WAIT = 1'b1
  } lfsr_fsm_e;

endpackage

// File: rtl/lfsr_multi_step.sv
// Combinational Fibonacci LFSR advanced STEPS times (shift left, parity of tapped bits in).
module lfsr_multi_step #(
  parameter int unsigned       WIDTH = 20,
  parameter logic [WIDTH-1:0]  TAPS  = 20'h90000,
  parameter int unsigned       STEPS = 3
) (
  input  logic [WIDTH-1:0] in_state,
  output logic [WIDTH-1:0] out_state
);

  logic [WIDTH-1:0] s;

  always_comb begin
    s = in_state;
    for (int unsigned i = 0; i < STEPS; i++) begin
      s = {s[WIDTH-2:0], ^(s & TAPS)};
    end
    out_state = s;
  end

endmodule

// File: rtl/lfsr_stream.sv
// LFSR random-word source: steps the LFSR several times per clock and presents
// OUT_BITS-wide words through a 1-deep valid/ready output register.
module lfsr_stream
  import lfsr_stream_pkg::*;
#(
  parameter int unsigned      WIDTH         = LFSR20_WIDTH,
  parameter logic [WIDTH-1:0] TAPS          = LFSR20_TAPS,
  parameter int unsigned      OUT_BITS      = 3,
  parameter int unsigned      STEPS_PER_CLK = 3,
  parameter logic [WIDTH-1:0] SEED_DEFAULT  = LFSR20_SEED_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int unsigned CYCLES = OUT_BITS / STEPS_PER_CLK;
  localparam int unsigned CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [WIDTH-1:0] SEED_INIT = (SEED_DEFAULT == '0) ? WIDTH'(1) : SEED_DEFAULT;

  lfsr_fsm_e        fsm;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] step_state;
  logic [CNT_W-1:0] cnt;
  logic             word_done_c;

  lfsr_multi_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS_PER_CLK)
  ) u_step (
    .in_state  (state),
    .out_state (step_state)
  );

  assign word_done_c = (cnt == CNT_W'(CYCLES - 1));

  // Zero seeds are remapped to 1 so the all-zero lock-up state is never entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED_INIT;
      out_data  <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      fsm       <= S_FILL;
      busy      <= 1'b1;
    end else if (seed_load) begin
      state     <= (seed == '0) ? WIDTH'(1) : seed;
      out_valid <= 1'b0;
      cnt       <= '0;
      fsm       <= S_FILL;
      busy      <= 1'b1;
    end else begin
      case (fsm)
        S_FILL: begin
          state <= step_state;
          if (word_done_c) begin
            cnt <= '0;
            if (!out_valid || out_ready) begin
              out_data  <= step_state[OUT_BITS-1:0];
              out_valid <= 1'b1;
            end else begin
              fsm  <= S_WAIT;
              busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          // out_valid is always high here; the frozen state already holds the next word.
          if (out_ready) begin
            out_data <= state[OUT_BITS-1:0];
            fsm      <= S_FILL;
            busy     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboard bench for lfsr_stream: two instances (3 steps/clk and 1 step/clk) share stimulus;
// expected words come from a behavioural LFSR sequence model.
module tb_lfsr_stream;

  localparam logic [19:0] TAPS = 20'h90000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load = 1'b0;
  logic        out_ready = 1'b0;
  logic [19:0] seed = '0;

  logic [2:0] data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b;

  int errs   = 0;
  int checks = 0;

  logic [2:0] q_a[$];
  logic [2:0] q_b[$];
  int         cyc[2];
  bit         hold[2];
  logic [2:0] held[2];
  bit         from_rst[2];
  int         hs[2];
  int         cpw[2] = '{1, 3};
  bit         armed = 1'b0;

  lfsr_stream #(
    .WIDTH(20), .TAPS(TAPS), .OUT_BITS(3), .STEPS_PER_CLK(3), .SEED_DEFAULT(20'd1)
  ) u_a (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready), .busy(busy_a)
  );

  lfsr_stream #(
    .WIDTH(20), .TAPS(TAPS), .OUT_BITS(3), .STEPS_PER_CLK(1), .SEED_DEFAULT(20'd1)
  ) u_b (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] lfsr_next(input logic [19:0] s);
    return {s[18:0], 1'($countones(s & TAPS) % 2)};
  endfunction

  // Expected word stream: low 3 bits after every 3 single steps from the (nonzero) seed.
  task automatic reload(input int k, input logic [19:0] sd);
    logic [19:0] s;
    s = (sd == 20'd0) ? 20'd1 : sd;
    if (k == 0) q_a.delete(); else q_b.delete();
    for (int n = 0; n < 160; n++) begin
      for (int b = 0; b < 3; b++) s = lfsr_next(s);
      if (k == 0) q_a.push_back(s[2:0]); else q_b.push_back(s[2:0]);
    end
    cyc[k]  = -1;
    hold[k] = 1'b0;
    hs[k]   = 0;
  endtask

  task automatic mon(input int k, input logic [2:0] d, input logic v, input logic b,
                     input logic [19:0] st);
    logic [2:0] exp_w;
    string      tag;
    int         depth;
    tag = (k == 0) ? "a" : "b";
    if (armed) begin
      if (cyc[k] < 1000000) cyc[k]++;
      if (cyc[k] < cpw[k]) chk({tag, "_valid_latency_low"}, 32'(v), 32'd0);
      else if (cyc[k] == cpw[k]) chk({tag, "_valid_latency_rise"}, 32'(v), 32'd1);
      if (from_rst[k] && cyc[k] < cpw[k]) begin
        chk({tag, "_reset_data"}, 32'(d), 32'd0);
        chk({tag, "_reset_busy"}, 32'(b), 32'd1);
      end
      if (hold[k]) begin
        chk({tag, "_hold_valid"}, 32'(v), 32'd1);
        chk({tag, "_hold_data"}, 32'(d), 32'(held[k]));
      end
      chk({tag, "_state_nonzero"}, 32'(st != 20'd0), 32'd1);
    end
    if (rst) begin
      reload(k, 20'd1);
      from_rst[k] = 1'b1;
    end else if (armed) begin
      hold[k] = v && !out_ready;
      held[k] = d;
      if (v && out_ready) begin
        hs[k]++;
        depth = (k == 0) ? q_a.size() : q_b.size();
        if (depth == 0) begin
          checks++;
          errs++;
          $display("FAIL %s_queue_underflow: got word %0h with no expected word", tag, d);
        end else begin
          if (k == 0) exp_w = q_a.pop_front(); else exp_w = q_b.pop_front();
          chk({tag, "_word"}, 32'(d), 32'(exp_w));
        end
      end
      if (seed_load) begin
        reload(k, seed);
        from_rst[k] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, data_a, valid_a, busy_a, u_a.state);
    mon(1, data_b, valid_b, busy_b, u_b.state);
    if (rst) armed = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [19:0] sd);
    tick();
    seed      = sd;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic at_negedge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int since;
    since = 0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reference sequence from seed 20'h10000 with the consumer always ready.
    out_ready = 1'b1;
    load_seed(20'h10000);
    at_negedge(); chk("a_state_c0", 32'(u_a.state), 32'h10000);
    at_negedge(); chk("a_state_c1", 32'(u_a.state), 32'h80004); chk("a_word1", 32'(data_a), 32'h4);
    at_negedge(); chk("a_state_c2", 32'(u_a.state), 32'h00024); chk("a_word2", 32'(data_a), 32'h4);
    at_negedge(); chk("a_state_c3", 32'(u_a.state), 32'h00120); chk("a_word3", 32'(data_a), 32'h0);
    chk("b_state_c3", 32'(u_b.state), 32'h80004);
    chk("b_word1", 32'(data_b), 32'h4);
    for (int i = 4; i <= 30; i++) begin
      at_negedge();
      chk("a_valid_continuous", 32'(valid_a), 32'd1);
      chk("a_busy_ready_high", 32'(busy_a), 32'd1);
      chk("b_busy_ready_high", 32'(busy_b), 32'd1);
    end
    chk("a_words_in_30_cycles", 32'(hs[0]), 32'd30);
    chk("b_words_in_30_cycles", 32'(hs[1]), 32'd10);

    // Backpressure: both engines park in WAIT with the word held.
    tick();
    out_ready = 1'b0;
    repeat (10) tick();
    at_negedge();
    chk("a_stall_valid", 32'(valid_a), 32'd1);
    chk("b_stall_valid", 32'(valid_b), 32'd1);
    chk("a_stall_busy", 32'(busy_a), 32'd0);
    chk("b_stall_busy", 32'(busy_b), 32'd0);
    tick();
    out_ready = 1'b1;
    repeat (20) tick();

    // Zero seed behaves as seed 1.
    load_seed(20'd0);
    at_negedge();
    chk("a_state_seed0", 32'(u_a.state), 32'd1);
    chk("b_state_seed0", 32'(u_b.state), 32'd1);
    repeat (20) tick();
    load_seed(20'd1);
    repeat (20) tick();

    // Flush a pending word, then reset mid-word.
    out_ready = 1'b0;
    load_seed(20'h10000);
    repeat (6) tick();
    at_negedge();
    chk("a_pending_before_flush", 32'(valid_a), 32'd1);
    chk("b_pending_before_flush", 32'(valid_b), 32'd1);
    load_seed(20'h5a5a5);
    at_negedge();
    chk("a_flush_valid", 32'(valid_a), 32'd0);
    chk("b_flush_valid", 32'(valid_b), 32'd0);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_negedge();
    chk("a_rst_valid", 32'(valid_a), 32'd0);
    chk("b_rst_valid", 32'(valid_b), 32'd0);
    chk("a_rst_data", 32'(data_a), 32'd0);
    chk("b_rst_data", 32'(data_b), 32'd0);
    chk("a_rst_busy", 32'(busy_a), 32'd1);
    chk("b_rst_busy", 32'(busy_b), 32'd1);
    chk("a_rst_state", 32'(u_a.state), 32'd1);
    chk("b_rst_state", 32'(u_b.state), 32'd1);

    // Random backpressure, reseeds (some zero) and occasional resets.
    tick();
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        since = 0;
      end else if (since >= 100 || $urandom_range(0, 59) == 0) begin
        seed      = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom);
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        since = 0;
      end else begin
        tick();
        since++;
      end
    end
    out_ready = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
